// File: rtl/mux12_arb_pkg.sv
// Shared constants and FSM state type for the 12-way packet arbiter.
package mux12_arb_pkg;

  localparam int N_REQ = 12;
  localparam int ID_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mux12_arb_if.sv
// Requester-side and output-side bus of the 12-way packet arbiter.
interface mux12_arb_if
  import mux12_arb_pkg::*;
#(
  parameter int DW = 32
);

  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    last;
  logic [N_REQ*DW-1:0] din;
  logic [N_REQ-1:0]    gnt;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic                out_last;
  logic [ID_W-1:0]     out_id;
  logic                out_ready;

  modport master (
    output req, last, din, out_ready,
    input  gnt, out_valid, out_data, out_last, out_id
  );

  modport slave (
    input  req, last, din, out_ready,
    output gnt, out_valid, out_data, out_last, out_id
  );

endinterface

// File: rtl/mux12_arb_mux12.sv
// One-hot select AND-OR data mux over twelve DW-bit lanes.
module mux12
  import mux12_arb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [N_REQ-1:0]    i_sel,
  input  logic [N_REQ*DW-1:0] i_din,
  output logic [DW-1:0]       o_dout
);

  always_comb begin
    // NOTE: the default assignment ahead of the loop keeps this block free of inferred latches.
    o_dout = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i_sel[i]) begin
        o_dout = o_dout | i_din[i*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/mux12_arb.sv
// Round-robin packet arbiter: locks one requester per packet and forwards its
// beats through a single registered output stage with ready/valid backpressure.
module mux12_arb
  import mux12_arb_pkg::*;
#(
  parameter int DW = 32,
  parameter int N  = N_REQ
) (
  input  logic       clk,
  input  logic       nreset,
  mux12_arb_if.slave bus
);

  state_e          r_state, w_state_nxt;
  logic [ID_W-1:0] r_ptr, w_ptr_nxt;
  logic [ID_W-1:0] r_owner, w_owner_nxt;

  logic            r_out_valid;
  logic [DW-1:0]   r_out_data;
  logic            r_out_last;
  logic [ID_W-1:0] r_out_id;

  logic [N-1:0]    w_owner_oh;
  logic [N-1:0]    w_gnt;
  logic [DW-1:0]   w_mux_data;
  logic            w_load_en;
  logic            w_req_own;
  logic            w_last_own;
  logic            w_gnt_any;

  // First set request at or after p, scanning upward and wrapping 11 -> 0.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0] r, input logic [ID_W-1:0] p);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(p) + k) % N;
      if (!found && r[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_owner_oh = N'(1) << r_owner;
  assign w_req_own  = |(bus.req & w_owner_oh);
  assign w_last_own = |(bus.last & w_owner_oh);
  assign w_load_en  = ~r_out_valid | bus.out_ready;
  assign w_gnt_any  = |w_gnt;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_gnt       = '0;
    case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_owner_nxt = rr_pick(bus.req, r_ptr);
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_req_own && w_load_en) begin
          w_gnt = w_owner_oh;
          if (w_last_own) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = (r_owner == ID_W'(N - 1)) ? '0 : r_owner + ID_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!nreset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  mux12 #(.DW(DW)) u_mux (
    .i_sel  (w_owner_oh),
    .i_din  (bus.din),
    .o_dout (w_mux_data)
  );

  // A grant both retires any held beat and loads the new one in the same edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_id    <= '0;
    end else if (w_gnt_any) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_data;
      r_out_last  <= w_last_own;
      r_out_id    <= r_owner;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.out_id    = r_out_id;

endmodule
